// File: rtl/checksum_pkg.sv
// Shared definitions for the streaming ones'-complement checksum block:
// checksum width, FSM state encoding and the end-around-carry adder.
package checksum_pkg;

  localparam int CSUM_W = 16;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    FOLD = 2'd1,
    OUT  = 2'd2
  } state_t;

  // 16-bit ones'-complement addition: the carry out of bit 15 is added back
  // in at bit 0. A second carry is impossible (max 0xFFFE + 1).
  function automatic logic [CSUM_W-1:0] ones_add16(input logic [CSUM_W-1:0] a,
                                                   input logic [CSUM_W-1:0] b);
    logic [CSUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CSUM_W-1:0] + {{(CSUM_W-1){1'b0}}, s[CSUM_W]};
  endfunction

endpackage

// File: rtl/csum_lane_adder.sv
// Combinational byte masking and 16-bit lane reduction for one stream beat.
// Bytes with a cleared keep bit are zeroed, then all DATA_W/16 lanes are
// summed with end-around carry into a single 16-bit partial sum.
module csum_lane_adder
  import checksum_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] keep,
  output logic [CSUM_W-1:0]   lane_sum
);

  localparam int BYTES = DATA_W / 8;
  localparam int LANES = DATA_W / 16;

  logic [DATA_W-1:0] masked;

  // Zero every byte not qualified by its keep bit.
  always_comb begin
    masked = '0;
    for (int j = 0; j < BYTES; j++) begin
      masked[8*j +: 8] = keep[j] ? data[8*j +: 8] : 8'h00;
    end
  end

  // Fold all lanes together; lane order is irrelevant to the result.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = ones_add16(lane_sum, masked[16*k +: 16]);
    end
  end

endmodule

// File: rtl/stream_checksum.sv
// Streaming Internet-style checksum: accumulates a packet beat by beat,
// folds to 16 bits and presents ~sum on a valid/ready result port.
// Optional feature: define STREAM_CHECKSUM_VERIFY_EN to add m_ok, which
// flags a packet whose ones'-complement sum is 0xFFFF (checksum verifies).
module stream_checksum
  import checksum_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int SEED_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_last,
  input  logic [CSUM_W-1:0]   s_seed,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CSUM_W-1:0]   m_checksum
`ifdef STREAM_CHECKSUM_VERIFY_EN
  ,
  output logic                m_ok
`endif
);

  state_t            state, state_nxt;
  logic [CSUM_W-1:0] acc;
  logic [CSUM_W-1:0] acc_base;
  logic [CSUM_W-1:0] lane_sum;
  logic              first_beat;
  logic              beat_acc;

  csum_lane_adder #(.DATA_W(DATA_W)) u_lanes (
    .data     (s_data),
    .keep     (s_keep),
    .lane_sum (lane_sum)
  );

  // Handshake outputs depend on state only, so no input-to-output path.
  assign s_ready  = (state == ACC);
  assign m_valid  = (state == OUT);
  assign beat_acc = s_valid && s_ready;

  // A new packet starts from the seed (or zero) instead of the old total.
  assign acc_base = first_beat ? ((SEED_EN != 0) ? s_seed : '0) : acc;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (beat_acc && s_last) state_nxt = FOLD;
      FOLD:    state_nxt = OUT;
      OUT:     if (m_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Running sum and packet-start flag, updated on every accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      first_beat <= 1'b1;
    end else if (beat_acc) begin
      acc        <= ones_add16(acc_base, lane_sum);
      first_beat <= s_last;
    end
  end

`ifdef STREAM_CHECKSUM_VERIFY_EN
  // Result registers, loaded once in FOLD and held through OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_checksum <= '0;
      m_ok       <= 1'b0;
    end else if (state == FOLD) begin
      m_checksum <= ~acc;
      m_ok       <= (acc == 16'hFFFF);
    end
  end
`else
  // Result register, loaded once in FOLD and held through OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_checksum <= '0;
    end else if (state == FOLD) begin
      m_checksum <= ~acc;
    end
  end
`endif

endmodule
